// File: rtl/i2c_write_master.sv
// Bit-level I2C write initiator: START, 7-bit address + W, one data byte, STOP, with slave ACK sampling.
// Optional SCL clock stretching is enabled by defining I2C_MASTER_CLK_STRETCH_EN.
module i2c_write_master #(
   parameter int DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic [7:0] data,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       nack
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
   } state_t;

   state_t     state, state_nx;
   logic [1:0] q, q_nx;
   logic [7:0] qcnt, qcnt_nx;
   logic [2:0] bitcnt, bit_nx;
   logic [7:0] sh, sh_nx;
   logic [7:0] dat, dat_nx;
   logic       nack_smp, nack_smp_nx;
   logic       nack_nx, done_nx;
   logic       hold, tick, phase_end;

   // Returns {scl_oe, sda_oe} for a given state, quarter and current bit.
   function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] qt, input logic b);
      logic [1:0] drv;
      case (st)
         S_START:        drv = {1'b0, qt[1]};
         S_ADDR, S_DATA: drv = {~qt[1], ~b};
         S_ACK1, S_ACK2: drv = {~qt[1], 1'b0};
         S_STOP:         drv = {~qt[1], (qt != 2'd3)};
         default:        drv = 2'b00;
      endcase
      return drv;
   endfunction

`ifdef I2C_MASTER_CLK_STRETCH_EN
   // A slave holding SCL low after we release it freezes the timer in q2.
   assign hold = (q == 2'd2) && !scl_in;
`else
   logic unused_scl_in;
   assign unused_scl_in = scl_in;
   assign hold          = 1'b0;
`endif

   assign tick      = !hold && (qcnt == 8'(DIV - 1));
   assign phase_end = tick && (q == 2'd3);

   always_comb begin
      state_nx    = state;
      q_nx        = q;
      qcnt_nx     = qcnt;
      bit_nx      = bitcnt;
      sh_nx       = sh;
      dat_nx      = dat;
      nack_smp_nx = nack_smp;
      nack_nx     = nack;
      done_nx     = 1'b0;

      if (state != S_IDLE) begin
         if (hold) begin
            qcnt_nx = '0;
         end else if (tick) begin
            qcnt_nx = '0;
            q_nx    = q + 2'd1;
         end else begin
            qcnt_nx = qcnt + 8'd1;
         end
      end

      case (state)
         S_IDLE: begin
            if (start) begin
               state_nx = S_START;
               sh_nx    = {addr, 1'b0};
               dat_nx   = data;
               nack_nx  = 1'b0;
               q_nx     = '0;
               qcnt_nx  = '0;
               bit_nx   = '0;
            end
         end
         S_START: begin
            if (phase_end) begin
               state_nx = S_ADDR;
               bit_nx   = '0;
            end
         end
         S_ADDR, S_DATA: begin
            if (phase_end) begin
               bit_nx = bitcnt + 3'd1;
               if (bitcnt == 3'd7)
                  state_nx = (state == S_ADDR) ? S_ACK1 : S_ACK2;
            end
         end
         S_ACK1, S_ACK2: begin
            if (tick && (q == 2'd2))
               nack_smp_nx = sda_in;
            if (phase_end) begin
               if (nack_smp) begin
                  nack_nx  = 1'b1;
                  state_nx = S_STOP;
               end else if (state == S_ACK1) begin
                  state_nx = S_DATA;
                  sh_nx    = dat;
                  bit_nx   = '0;
               end else begin
                  state_nx = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (phase_end) begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Line drives are decoded from next-state values so the registered outputs line up with the phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         q        <= '0;
         qcnt     <= '0;
         bitcnt   <= '0;
         nack_smp <= 1'b0;
         nack     <= 1'b0;
         done     <= 1'b0;
         busy     <= 1'b0;
         scl_oe   <= 1'b0;
         sda_oe   <= 1'b0;
      end else begin
         state              <= state_nx;
         q                  <= q_nx;
         qcnt               <= qcnt_nx;
         bitcnt             <= bit_nx;
         nack_smp           <= nack_smp_nx;
         nack               <= nack_nx;
         done               <= done_nx;
         busy               <= (state_nx != S_IDLE);
         {scl_oe, sda_oe}   <= line_drive(state_nx, q_nx, sh_nx[3'd7 - bit_nx]);
      end
   end

   always_ff @(posedge clk) begin
      sh  <= sh_nx;
      dat <= dat_nx;
   end

endmodule

// File: tb/tb_i2c_write_master.sv
// Randomized self-checking bench for i2c_write_master: a bus-level slave/monitor compared with a frame-level model.
module tb_i2c_write_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic [1:0] start_v, pull_v, hold_v;
   logic [6:0] addr_s [2];
   logic [7:0] data_s [2];
   logic       scl_oe0, sda_oe0, busy0, done0, nack0;
   logic       scl_oe1, sda_oe1, busy1, done1, nack1;

   wire scl_in0 = ~scl_oe0 & ~hold_v[0];
   wire scl_in1 = ~scl_oe1 & ~hold_v[1];
   wire sda_in0 = ~(sda_oe0 | pull_v[0]);
   wire sda_in1 = ~(sda_oe1 | pull_v[1]);

   i2c_write_master #(.DIV(2)) u_dut_div2 (
      .clk(clk), .reset(reset), .start(start_v[0]), .addr(addr_s[0]), .data(data_s[0]),
      .scl_in(scl_in0), .sda_in(sda_in0), .scl_oe(scl_oe0), .sda_oe(sda_oe0),
      .busy(busy0), .done(done0), .nack(nack0));

   i2c_write_master #(.DIV(4)) u_dut_div4 (
      .clk(clk), .reset(reset), .start(start_v[1]), .addr(addr_s[1]), .data(data_s[1]),
      .scl_in(scl_in1), .sda_in(sda_in1), .scl_oe(scl_oe1), .sda_oe(sda_oe1),
      .busy(busy1), .done(done1), .nack(nack1));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // {scl_oe, sda_oe, busy, done, nack} of the selected instance
   function automatic logic [4:0] outs(input int w);
      return (w == 0) ? {scl_oe0, sda_oe0, busy0, done0, nack0}
                      : {scl_oe1, sda_oe1, busy1, done1, nack1};
   endfunction

   // One write frame on instance w. The slave ACKs byte n when ackn=1. Optional extras: SCL hold after
   // rise hold_rise, a stray start pulse at rise mid_rise, a reset at rise rst_rise, start kept high (keep).
   task automatic run_txn(input int w, input logic [6:0] a, input logic [7:0] d,
                          input bit ack1, input bit ack2, input int hold_rise, input int hold_len,
                          input int mid_rise, input int rst_rise, input bit keep);
      int          div, t, cyc, rises, starts, stops, hold_cnt, exp_cyc, exp_n;
      bit          prev_scl, prev_sda, cur_scl, cur_sda, busy_drop, mid_off, saw_done;
      bit          obs_q[$];
      logic [31:0] ev, ov;
      logic [4:0]  o;
      div = (w == 0) ? 2 : 4;

      // frame-level model: SDA seen at every SCL rise, and the frame length in phases
      ev = '0; exp_n = 0;
      for (int i = 6; i >= 0; i--) begin ev = {ev[30:0], a[i]}; exp_n++; end
      ev = {ev[30:0], 1'b0};  exp_n++;
      ev = {ev[30:0], !ack1}; exp_n++;
      if (ack1) begin
         for (int i = 7; i >= 0; i--) begin ev = {ev[30:0], d[i]}; exp_n++; end
         ev = {ev[30:0], !ack2}; exp_n++;
      end
      ev = {ev[30:0], 1'b0}; exp_n++;
      exp_cyc = (ack1 ? 20 : 11) * 4 * div;
`ifdef I2C_MASTER_CLK_STRETCH_EN
      if (hold_rise > 0) exp_cyc += hold_len;
`endif

      addr_s[w] = a; data_s[w] = d; start_v[w] = 1'b1;
      t = 0;
      while (!outs(w)[2] && t < 50) begin @(negedge clk); t++; end
      chk("accept", outs(w)[2], 1'b1);
      if (!outs(w)[2]) begin start_v[w] = 1'b0; return; end
      chk("nack_clear", outs(w)[0], 1'b0);
      if (!keep) begin
         start_v[w] = 1'b0;
         addr_s[w]  = 7'($urandom);
         data_s[w]  = 8'($urandom);
      end

      prev_scl = 1'b1; prev_sda = 1'b1; cyc = 0; rises = 0; starts = 0; stops = 0;
      hold_cnt = 0; busy_drop = 1'b0; mid_off = 1'b0;
      while (cyc < 2000) begin
         @(negedge clk); cyc++;
         if (mid_off) begin start_v[w] = 1'b0; mid_off = 1'b0; end
         if (hold_cnt > 0) begin
            hold_cnt--;
            if (hold_cnt == 0) hold_v[w] = 1'b0;
         end
         o       = outs(w);
         cur_scl = ~o[4];
         cur_sda = ~(o[3] | pull_v[w]);
         if (prev_scl && cur_scl && prev_sda && !cur_sda) starts++;
         if (prev_scl && cur_scl && !prev_sda && cur_sda) stops++;
         if (!prev_scl && cur_scl) begin
            rises++;
            obs_q.push_back(cur_sda);
            if (rises == hold_rise) begin hold_v[w] = 1'b1; hold_cnt = hold_len; end
            if (rises == mid_rise) begin start_v[w] = 1'b1; mid_off = 1'b1; end
            if (rises == rst_rise) begin
               reset = 1'b1;
               @(negedge clk);
               chk("rst_mid_lines", {outs(w)[4:3], outs(w)[2], outs(w)[0]}, 4'b0000);
               reset = 1'b0;
               saw_done = outs(w)[1];
               repeat (3) begin @(negedge clk); saw_done |= outs(w)[1]; end
               chk("rst_mid_no_done", saw_done, 1'b0);
               pull_v[w] = 1'b0; hold_v[w] = 1'b0; start_v[w] = 1'b0;
               return;
            end
         end
         if (prev_scl && !cur_scl)
            pull_v[w] = ((rises == 8) && ack1) || ((rises == 17) && ack2);
         if (o[1]) break;
         if (!o[2]) busy_drop = 1'b1;
         prev_scl = cur_scl; prev_sda = cur_sda;
      end

      ov = '0;
      foreach (obs_q[i]) ov = {ov[30:0], obs_q[i]};
      chk("done_seen", outs(w)[1], 1'b1);
      chk("latency", cyc, exp_cyc);
      chk("nack", outs(w)[0], (!ack1 || !ack2));
      chk("busy_at_done", outs(w)[2], 1'b0);
      chk("busy_held", busy_drop, 1'b0);
      chk("bit_count", obs_q.size(), exp_n);
      chk("sda_bits", ov, ev);
      chk("start_cond", starts, 1);
      chk("stop_cond", stops, 1);
      pull_v[w] = 1'b0; hold_v[w] = 1'b0;
      @(negedge clk);
      chk("done_pulse_len", outs(w)[1], 1'b0);
      if (keep) chk("back_to_back", outs(w)[2], 1'b1);
   endtask

   initial begin
      reset = 1'b1; start_v = '0; pull_v = '0; hold_v = '0;
      addr_s[0] = '0; addr_s[1] = '0; data_s[0] = '0; data_s[1] = '0;
      repeat (3) @(negedge clk);
      chk("reset_div2", outs(0), 5'b0);
      chk("reset_div4", outs(1), 5'b0);
      reset = 1'b0;
      @(negedge clk);

      run_txn(0, 7'h50, 8'hA5, 1, 1, 0, 0, 0, 0, 0);                  // reference frame, 160 clocks
      run_txn(0, 7'($urandom), 8'($urandom), 0, 0, 0, 0, 0, 0, 0);    // address NACK, 88 clocks
      run_txn(0, 7'h2C, 8'h3C, 1, 0, 0, 0, 0, 0, 0);                  // data NACK
      run_txn(0, 7'h11, 8'hFF, 1, 1, 0, 0, 0, 0, 0);                  // nack cleared on accept
      run_txn(0, 7'h7F, 8'h00, 1, 1, 0, 0, 12, 0, 0);                 // stray start during DATA
      run_txn(0, 7'h33, 8'h5A, 1, 1, 0, 0, 0, 0, 1);                  // start held high
      run_txn(0, 7'h33, 8'h5A, 1, 1, 0, 0, 0, 0, 0);
      run_txn(0, 7'h24, 8'hC3, 1, 1, 0, 0, 0, 14, 0);                 // reset in DATA bit 4
      run_txn(0, 7'h01, 8'h80, 1, 1, 0, 0, 0, 0, 0);
      run_txn(1, 7'h50, 8'hA5, 1, 1, 4, 10, 0, 0, 0);                 // SCL held low in ADDR bit 3
      repeat (10) begin
         run_txn(int'($urandom_range(0, 1)), 7'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), 0, 0, 0, 0, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
